// File: rtl/dispense_pkg.sv
// Shared types and the colour recipe table for the paint dispense path.
package dispense_pkg;

  typedef enum logic [2:0] {IDLE, SEL, DROP, GAP, DONE} state_e;
  typedef enum logic [1:0] {CH_R, CH_Y, CH_B} ch_e;

  localparam int NUM_COLORS = 8;
  localparam int STROKE_W   = 3;

  typedef struct packed {
    logic [STROKE_W-1:0] r;
    logic [STROKE_W-1:0] y;
    logic [STROKE_W-1:0] b;
    logic                valid;
  } recipe_t;

  // Strokes per channel for each supported colour_id.
  localparam recipe_t RECIPE_TBL [NUM_COLORS] = '{
    '{r: 3'd2, y: 3'd4, b: 3'd7, valid: 1'b1},
    '{r: 3'd5, y: 3'd0, b: 3'd0, valid: 1'b1},
    '{r: 3'd0, y: 3'd5, b: 3'd0, valid: 1'b1},
    '{r: 3'd0, y: 3'd0, b: 3'd5, valid: 1'b1},
    '{r: 3'd3, y: 3'd3, b: 3'd0, valid: 1'b1},
    '{r: 3'd0, y: 3'd3, b: 3'd3, valid: 1'b1},
    '{r: 3'd3, y: 3'd0, b: 3'd3, valid: 1'b1},
    '{r: 3'd2, y: 3'd2, b: 3'd2, valid: 1'b1}
  };

  function automatic recipe_t recipe_lookup(input logic [3:0] id);
    recipe_t rec;
    if (id[3]) rec = '0;
    else       rec = RECIPE_TBL[id[2:0]];
    return rec;
  endfunction

  function automatic ch_e next_ch(input ch_e c);
    ch_e n;
    case (c)
      CH_R:    n = CH_Y;
      CH_Y:    n = CH_B;
      default: n = CH_B;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/dispense_recipe_rom.sv
// Combinational colour_id -> recipe lookup, shared with order-entry logic.
module dispense_recipe_rom
  import dispense_pkg::*;
(
  input  logic [3:0] color_id_i,
  output recipe_t    recipe_o
);

  assign recipe_o = recipe_lookup(color_id_i);

endmodule

// File: rtl/dispense_scheduler.sv
// Grants the motor enable to one paint channel at a time and sequences push/retract strokes.
// Optional pause input is enabled with `define DISPENSE_PAUSE_EN.
module dispense_scheduler
  import dispense_pkg::*;
#(
  parameter int DEPTH     = 5,
  parameter int GAP_TICKS = 2,
  parameter int CNT_W     = 10
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       step_tick_i,
  input  logic       start_i,
  input  logic [3:0] color_id_i,
  input  logic       abort_i,
`ifdef DISPENSE_PAUSE_EN
  input  logic       pause_i,
`endif
  output logic       en_r_o,
  output logic       en_y_o,
  output logic       en_b_o,
  output logic       dir_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       bad_color_o,
  output state_e     dbg_state_o
);

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(2 * DEPTH - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);

  state_e              state_q, state_d;
  ch_e                 ch_q, ch_d;
  logic [CNT_W-1:0]    tick_q, tick_d;
  logic [CNT_W-1:0]    stroke_q, stroke_d;
  logic [STROKE_W-1:0] tgt_r_q, tgt_r_d, tgt_y_q, tgt_y_d, tgt_b_q, tgt_b_d;
  logic                en_r_q, en_r_d, en_y_q, en_y_d, en_b_q, en_b_d;
  logic                dir_q, dir_d, busy_q, busy_d, done_q, done_d, bad_q, bad_d;

  recipe_t             rom_rec;
  logic                pause_in;
  logic                tick_en;
  logic [STROKE_W-1:0] cur_tgt;
  logic                later_nz;

  dispense_recipe_rom u_rom (
    .color_id_i (color_id_i),
    .recipe_o   (rom_rec)
  );

`ifdef DISPENSE_PAUSE_EN
  assign pause_in = pause_i;
`else
  assign pause_in = 1'b0;
`endif

  // A paused order ignores ticks so its tick/stroke position is preserved.
  assign tick_en = step_tick_i && !pause_in;

  always_comb begin
    cur_tgt  = '0;
    later_nz = 1'b0;
    case (ch_q)
      CH_R: begin
        cur_tgt  = tgt_r_q;
        later_nz = (tgt_y_q != '0) || (tgt_b_q != '0);
      end
      CH_Y: begin
        cur_tgt  = tgt_y_q;
        later_nz = (tgt_b_q != '0);
      end
      default: begin
        cur_tgt  = tgt_b_q;
        later_nz = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    tick_d   = tick_q;
    stroke_d = stroke_q;
    tgt_r_d  = tgt_r_q;
    tgt_y_d  = tgt_y_q;
    tgt_b_d  = tgt_b_q;
    case (state_q)
      IDLE: begin
        if (start_i && rom_rec.valid) begin
          tgt_r_d = rom_rec.r;
          tgt_y_d = rom_rec.y;
          tgt_b_d = rom_rec.b;
          ch_d    = CH_R;
          state_d = SEL;
        end
      end
      SEL: begin
        if (cur_tgt == '0) begin
          if (ch_q == CH_B) state_d = DONE;
          else              ch_d    = next_ch(ch_q);
        end else begin
          tick_d   = '0;
          stroke_d = '0;
          state_d  = DROP;
        end
      end
      DROP: begin
        if (tick_en) begin
          if (tick_q == TICK_LAST) begin
            tick_d   = '0;
            stroke_d = stroke_q + CNT_W'(1);
            if (stroke_d == CNT_W'(cur_tgt)) state_d = later_nz ? GAP : DONE;
          end else begin
            tick_d = tick_q + CNT_W'(1);
          end
        end
      end
      GAP: begin
        if (tick_en) begin
          if (tick_q == GAP_LAST) begin
            tick_d  = '0;
            ch_d    = next_ch(ch_q);
            state_d = SEL;
          end else begin
            tick_d = tick_q + CNT_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_i && state_q != IDLE) state_d = IDLE;
  end

  // Outputs are derived from the next state so they register alongside it.
  always_comb begin
    en_r_d = (state_d == DROP) && (ch_d == CH_R) && !pause_in;
    en_y_d = (state_d == DROP) && (ch_d == CH_Y) && !pause_in;
    en_b_d = (state_d == DROP) && (ch_d == CH_B) && !pause_in;
    dir_d  = (state_d == DROP) && (tick_d >= DEPTH_C);
    busy_d = (state_d != IDLE);
    done_d = (state_q == DONE) && !abort_i;
    bad_d  = (state_q == IDLE) && start_i && !rom_rec.valid;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      ch_q     <= CH_R;
      tick_q   <= '0;
      stroke_q <= '0;
      tgt_r_q  <= '0;
      tgt_y_q  <= '0;
      tgt_b_q  <= '0;
      en_r_q   <= 1'b0;
      en_y_q   <= 1'b0;
      en_b_q   <= 1'b0;
      dir_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      tick_q   <= tick_d;
      stroke_q <= stroke_d;
      tgt_r_q  <= tgt_r_d;
      tgt_y_q  <= tgt_y_d;
      tgt_b_q  <= tgt_b_d;
      en_r_q   <= en_r_d;
      en_y_q   <= en_y_d;
      en_b_q   <= en_b_d;
      dir_q    <= dir_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      bad_q    <= bad_d;
    end
  end

  assign en_r_o      = en_r_q;
  assign en_y_o      = en_y_q;
  assign en_b_o      = en_b_q;
  assign dir_o       = dir_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign bad_color_o = bad_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dispense_scheduler.sv
// Bench for dispense_scheduler: randomized tick spacing, per-tick trace compared to a recipe-derived segment list.
module tb_dispense_scheduler;
  import dispense_pkg::*;

  localparam int DEPTH     = 5;
  localparam int GAP_TICKS = 2;
  localparam int CNT_W     = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       step_tick = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] color_id = 4'd0;
`ifdef DISPENSE_PAUSE_EN
  logic       pause = 1'b0;
`endif
  logic       en_r, en_y, en_b, dir, busy, done, bad_color;
  state_e     dbg_state;

  int checks = 0;
  int errors = 0;
  int tick_period = 4;
  logic tick_run = 1'b0;
  int done_cnt = 0;
  int bad_cnt = 0;
  logic [3:0]  tick_log[$];
  logic [15:0] exp_q[$];

  int rcp_r[8] = '{2, 5, 0, 0, 3, 0, 3, 2};
  int rcp_y[8] = '{4, 0, 5, 0, 3, 3, 0, 2};
  int rcp_b[8] = '{7, 0, 0, 5, 0, 3, 3, 2};

  always #5 clk = ~clk;

  dispense_scheduler #(.DEPTH(DEPTH), .GAP_TICKS(GAP_TICKS), .CNT_W(CNT_W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .step_tick_i (step_tick),
    .start_i     (start),
    .color_id_i  (color_id),
    .abort_i     (abort),
`ifdef DISPENSE_PAUSE_EN
    .pause_i     (pause),
`endif
    .en_r_o      (en_r),
    .en_y_o      (en_y),
    .en_b_o      (en_b),
    .dir_o       (dir),
    .busy_o      (busy),
    .done_o      (done),
    .bad_color_o (bad_color),
    .dbg_state_o (dbg_state)
  );

  // Tick driver: logs the outputs the DUT sees together with each tick.
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      step_tick = 1'b0;
      if (tick_run) begin
        cnt++;
        if (cnt >= tick_period) begin
          cnt = 0;
          step_tick = 1'b1;
          tick_log.push_back({dir, en_b, en_y, en_r});
        end
      end
    end
  end

  // Per-clock monitor: one-hot enables, no enable while idle, pulse counting.
  initial begin
    forever begin
      @(negedge clk);
      checks++;
      if ((int'(en_r) + int'(en_y) + int'(en_b)) > 1 || (!busy && (en_r || en_y || en_b))) begin
        errors++;
        $display("FAIL onehot: en_r=%0b en_y=%0b en_b=%0b busy=%0b", en_r, en_y, en_b, busy);
      end
      if (done) done_cnt++;
      if (bad_color) bad_cnt++;
    end
  end

  function automatic int enc(input logic [3:0] e);
    if (e[0]) return 1;
    if (e[1]) return 2;
    if (e[2]) return 3;
    return 0;
  endfunction

  function automatic int count_code(input int code);
    int n = 0;
    foreach (tick_log[k]) if (enc(tick_log[k]) == code) n++;
    return n;
  endfunction

  task automatic start_order(input int c);
    bit first = 1'b1;
    int n;
    exp_q.delete();
    for (int ch = 0; ch < 3; ch++) begin
      n = (ch == 0) ? rcp_r[c] : (ch == 1) ? rcp_y[c] : rcp_b[c];
      if (n > 0) begin
        if (!first) exp_q.push_back({2'd0, 14'(GAP_TICKS)});
        exp_q.push_back({2'(ch + 1), 14'(n * 2 * DEPTH)});
        first = 1'b0;
      end
    end
    tick_period = $urandom_range(3, 6);
    @(negedge clk);
    tick_log.delete();
    done_cnt = 0;
    start = 1'b1;
    color_id = 4'(c);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start c=%0d: got %0b want 1", c, busy);
    end
  endtask

  task automatic check_trace(input string name);
    logic [15:0] obs[$];
    int cur = -1;
    int len = 0;
    int dir_err = 0;
    int code;
    logic want_dir;
    foreach (tick_log[k]) begin
      code = enc(tick_log[k]);
      if (code != cur) begin
        if (cur >= 0) obs.push_back({2'(cur), 14'(len)});
        cur = code;
        len = 0;
      end
      if (code != 0) begin
        want_dir = ((len % (2 * DEPTH)) >= DEPTH);
        if (tick_log[k][3] !== want_dir) dir_err++;
      end
      len++;
    end
    if (cur >= 0) obs.push_back({2'(cur), 14'(len)});
    while (obs.size() > 0 && obs[0][15:14] == 2'd0) void'(obs.pop_front());
    while (obs.size() > 0 && obs[obs.size()-1][15:14] == 2'd0) void'(obs.pop_back());
    checks++;
    if (obs.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s segments: got %0d want %0d", name, obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s seg%0d: got ch=%0d len=%0d want ch=%0d len=%0d", name, i,
                 obs[i][15:14], obs[i][13:0], exp_q[i][15:14], exp_q[i][13:0]);
      end
    end
    checks++;
    if (dir_err != 0) begin
      errors++;
      $display("FAIL %s dir: got %0d wrong ticks want 0", name, dir_err);
    end
  endtask

  task automatic finish_order(input string name);
    int waited = 0;
    while (done_cnt == 0 && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL %s timeout: got no done want done", name);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL %s done_count: got %0d want 1", name, done_cnt);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_end: got %0b want 0", name, busy);
    end
    check_trace(name);
  endtask

  task automatic wait_ticks(input int code, input int n, input string name);
    int waited = 0;
    while (count_code(code) < n && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (count_code(code) < n) begin
      errors++;
      $display("FAIL %s wait: got %0d ticks want %0d", name, count_code(code), n);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({en_r, en_y, en_b, dir, busy, done, bad_color} !== 7'b0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_outputs: got %b state=%0d want 0000000 state=0",
               {en_r, en_y, en_b, dir, busy, done, bad_color}, dbg_state);
    end
    rst_n = 1'b1;
    tick_run = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({en_r, en_y, en_b, busy} !== 4'b0) begin
      errors++;
      $display("FAIL reset_release: got %b want 0000", {en_r, en_y, en_b, busy});
    end
  endtask

  task automatic test_recipes();
    for (int c = 0; c < NUM_COLORS; c++) begin
      start_order(c);
      finish_order($sformatf("colour%0d", c));
    end
  endtask

  task automatic test_bad_color();
    int c = $urandom_range(8, 15);
    bit leak = 1'b0;
    bad_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    color_id = 4'(c);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (bad_color !== 1'b1) begin
      errors++;
      $display("FAIL bad_color_pulse id=%0d: got %0b want 1", c, bad_color);
    end
    repeat (6) begin
      @(negedge clk);
      if (busy || en_r || en_y || en_b) leak = 1'b1;
    end
    checks++;
    if (leak) begin
      errors++;
      $display("FAIL bad_color_busy id=%0d: got activity want none", c);
    end
    checks++;
    if (bad_cnt != 1) begin
      errors++;
      $display("FAIL bad_color_count id=%0d: got %0d want 1", c, bad_cnt);
    end
  endtask

  task automatic test_abort();
    start_order(7);
    wait_ticks(2, 15, "abort_wait");
    abort = 1'b1;
    @(negedge clk);
    checks++;
    if ({en_r, en_y, en_b, busy} !== 4'b0) begin
      errors++;
      $display("FAIL abort_outputs: got %b want 0000", {en_r, en_y, en_b, busy});
    end
    abort = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (done_cnt != 0) begin
      errors++;
      $display("FAIL abort_done: got %0d want 0", done_cnt);
    end
    start_order(2);
    finish_order("after_abort_c2");
  endtask

  task automatic test_start_while_busy();
    start_order(4);
    wait_ticks(1, 5, "second_start_wait");
    start = 1'b1;
    color_id = 4'd3;
    @(negedge clk);
    start = 1'b0;
    finish_order("start_while_busy");
  endtask

  task automatic test_start_abort_same();
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    color_id = 4'($urandom_range(0, 7));
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL start_abort_first: got busy=%0b want 1", busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_abort_second: got busy=%0b want 0", busy);
    end
    abort = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt != 0) begin
      errors++;
      $display("FAIL start_abort_done: got %0d want 0", done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    start_order(6);
    wait_ticks(3, $urandom_range(5, 20), "reset_mid_wait");
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({en_r, en_y, en_b, dir, busy, done, bad_color} !== 7'b0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %b state=%0d want 0000000 state=0",
               {en_r, en_y, en_b, dir, busy, done, bad_color}, dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (done_cnt != 0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_mid_idle: got done=%0d state=%0d want 0 0", done_cnt, dbg_state);
    end
    start_order(5);
    finish_order("after_reset_c5");
  endtask

  initial begin
    test_reset();
    test_recipes();
    test_bad_color();
    test_abort();
    test_start_while_busy();
    test_start_abort_same();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
